axi_write_arbiter: RTL and testbench
====================================

Name: axi_write_arbiter

Overview:
- Arbitrates write transactions from NUM_M AXI masters onto the single shared write path in front of the AW slave-select mux.
- Grants one master round-robin and forwards its AW, W and B channels. Holds the grant until that master's B handshake completes.
- Addresses outside the mapped region (top nibble > 4'h3) get a local DECERR response, so the downstream mux is never presented an unmapped AWVALID.
- Sits between the master ports and the AW/W/B slave muxes inside the interconnect.

Parameters:
- NUM_M, 2, number of requesting masters (2..4).
- DW, 32, write data width; strobe width is DW/8.
- NUM_SLV, 4, number of mapped slaves; decodes addr[`ADDR_WIDTH-1-:4] < NUM_SLV.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_awvalid  in  NUM_M  per-master AWVALID
- m_awaddr  in  NUM_M*`ADDR_WIDTH  per-master AWADDR; master i occupies slice i
- m_awready  out  NUM_M  per-master AWREADY
- m_wvalid, m_wlast  in  NUM_M each  per-master W handshake and last beat
- m_wdata  in  NUM_M*DW  per-master write data
- m_wstrb  in  NUM_M*DW/8  per-master write strobes
- m_wready  out  NUM_M  per-master WREADY
- m_bvalid  out  NUM_M  per-master BVALID
- m_bresp  out  2  B response, valid with the granted master's m_bvalid
- m_bready  in  NUM_M  per-master BREADY
- awvalid, awaddr  out  1, `ADDR_WIDTH  to the slave AW mux
- awready  in  1  from the slave AW mux
- wvalid, wlast, wdata, wstrb  out  1, 1, DW, DW/8  to the W path
- wready  in  1  from the W path
- bvalid, bresp  in  1, 2  from the B path
- bready  out  1  to the B path
- grant_o  out  $clog2(NUM_M)  current owner index, for the W/B muxes
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst_i sampled high at a clk_i edge):
  - state = IDLE, rr_ptr = 0, grant_o = 0.
  - All valid/ready outputs go 0; m_bresp = 2'b00.
  - Takes effect mid-transaction. An in-flight transaction is abandoned without a B response.
- States: IDLE, AW, W, B, ERR_W, ERR_B.
- IDLE:
  - If any m_awvalid is high, choose the first requester at or after rr_ptr (wrapping modulo NUM_M).
  - Register its index into grant_o and its address into a capture register.
  - Next state is AW if the decode hits (nibble < NUM_SLV), else ERR_W.
  - Arbitration adds one cycle; no AW handshake occurs in the IDLE cycle.
- AW:
  - awvalid = 1, awaddr = captured address.
  - m_awready[grant_o] = awready.
  - On awvalid && awready, go to W.
  - The master must hold m_awvalid and address stable (AXI rule). The captured address is used regardless.
- W:
  - Forward the granted master's wvalid/wlast/wdata/wstrb; m_wready[grant_o] = wready.
  - On a handshake with wlast = 1, go to B.
  - W beats issued before the AW handshake are not accepted (wready to the master is 0 outside W).
- B:
  - m_bvalid[grant_o] = bvalid, m_bresp = bresp, bready = m_bready[grant_o].
  - On the handshake: rr_ptr = grant_o+1 modulo NUM_M, then return to IDLE.
- ERR_W:
  - m_awready[grant_o] = 1 on the first cycle only (one-cycle AW accept).
  - Then m_wready[grant_o] = 1, sinking beats until a wlast handshake; go to ERR_B.
  - Nothing is driven downstream.
- ERR_B:
  - m_bvalid[grant_o] = 1, m_bresp = 2'b11 (DECERR) until m_bready; then update rr_ptr and return to IDLE.
- Non-granted masters always see ready/bvalid = 0.
- Simultaneous requests: only rr_ptr decides priority. A master that has just finished has lowest priority next time.
- Requests arriving in the same cycle as the B handshake are considered in the following IDLE cycle.
- One outstanding transaction at a time; no pipelining across masters.
- All outputs are combinational from the state and grant registers plus the granted inputs. No combinational path runs from m_awvalid to a downstream output.

Decomposition:
- Shared package axi_ic_pkg:
  - typedef of the state enum.
  - localparams RESP_OKAY = 2'b00, RESP_DECERR = 2'b11.
  - localparam NUM_SLV_DEFAULT.
  - Function addr_hit(addr) implementing the top-nibble decode, shared with the AW mux.
- Sub-module rr_arbiter (NUM_M):
  - Inputs: req, ptr. Outputs: grant index, any_req.
  - Purely combinational, reused by the AR arbiter.

Test Plan:
- Single master 0, awaddr 0x1000_0000, 4 beats, bresp OKAY:
  - awvalid rises 1 cycle after m_awvalid; grant_o = 0.
  - Exactly 4 wvalid handshakes; m_bvalid[0] with bresp 00; busy_o falls after the B handshake.
- Masters 0 and 1 request in the same cycle from reset:
  - Grant order 0, 1, 0, 1 across four back-to-back transactions.
  - m_awready[1] stays 0 throughout master 0's transaction.
- Master 1 awaddr 0x7000_0000 with 2 beats:
  - awvalid never asserted; both beats accepted locally.
  - m_bvalid[1] with m_bresp = 2'b11, then master 0 is served normally.
- Downstream awready held low 5 cycles, wready toggling:
  - awaddr stays stable and beats are forwarded only on handshakes.
  - No data loss; wlast forwarded exactly once.
- rst_i pulsed high during W after 2 of 4 beats:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new request from master 1 completes with OKAY.
- bvalid held high with m_bready[0] low for 3 cycles:
  - bready follows m_bready; the grant is held.
  - Release and rr_ptr update happen only on the handshake cycle.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: FSM state encoding, AXI response codes and
// the slave-select address decode used by both the write arbiter and the AW mux.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package axi_ic_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int NUM_SLV_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AW    = 3'd1,
    ST_W     = 3'd2,
    ST_B     = 3'd3,
    ST_ERR_W = 3'd4,
    ST_ERR_B = 3'd5
  } state_t;

  // Top address nibble selects the slave; anything at or above num_slv is unmapped.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input int num_slv = NUM_SLV_DEFAULT);
    return (int'({1'b0, addr[ADDR_W-1 -: 4]}) < num_slv);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Shared between the AW and AR arbiters.
module rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int GW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [GW-1:0]    grant,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = (int'(ptr) + i) % NUM_M;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = GW'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin write arbiter: one master owns AW/W/B until its B handshake;
// unmapped addresses are absorbed locally and answered with DECERR.
module axi_write_arbiter
  import axi_ic_pkg::*;
#(
  parameter  int NUM_M   = 2,
  parameter  int DW      = 32,
  parameter  int NUM_SLV = NUM_SLV_DEFAULT,
  localparam int GW      = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SW      = DW / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_M-1:0]          m_awvalid,
  input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
  output logic [NUM_M-1:0]          m_awready,
  input  logic [NUM_M-1:0]          m_wvalid,
  input  logic [NUM_M-1:0]          m_wlast,
  input  logic [NUM_M*DW-1:0]       m_wdata,
  input  logic [NUM_M*SW-1:0]       m_wstrb,
  output logic [NUM_M-1:0]          m_wready,
  output logic [NUM_M-1:0]          m_bvalid,
  output logic [1:0]                m_bresp,
  input  logic [NUM_M-1:0]          m_bready,
  output logic                      awvalid,
  output logic [ADDR_W-1:0]         awaddr,
  input  logic                      awready,
  output logic                      wvalid,
  output logic                      wlast,
  output logic [DW-1:0]             wdata,
  output logic [SW-1:0]             wstrb,
  input  logic                      wready,
  input  logic                      bvalid,
  input  logic [1:0]                bresp,
  output logic                      bready,
  output logic [GW-1:0]             grant_o,
  output logic                      busy_o
);

  state_t              state;
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       next_ptr;
  logic [GW-1:0]       arb_grant;
  logic                any_req;
  logic                err_aw_first;
  logic [ADDR_W-1:0]   aw_addr_p0;
  logic [ADDR_W-1:0]   req_addr;

  rr_arbiter #(
    .NUM_M (NUM_M),
    .GW    (GW)
  ) u_rr (
    .req     (m_awvalid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  assign req_addr = m_awaddr[arb_grant*ADDR_W +: ADDR_W];
  assign next_ptr = (grant_o == GW'(NUM_M - 1)) ? '0 : grant_o + GW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_o      <= '0;
      err_aw_first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_o      <= arb_grant;
            err_aw_first <= 1'b1;
            state        <= addr_hit(req_addr, NUM_SLV) ? ST_AW : ST_ERR_W;
          end
        end
        ST_AW: if (awready) state <= ST_W;
        ST_W: begin
          if (m_wvalid[grant_o] && wready && m_wlast[grant_o]) state <= ST_B;
        end
        ST_B: begin
          if (bvalid && m_bready[grant_o]) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        ST_ERR_W: begin
          if (err_aw_first) err_aw_first <= 1'b0;
          else if (m_wvalid[grant_o] && m_wlast[grant_o]) state <= ST_ERR_B;
        end
        ST_ERR_B: begin
          if (m_bready[grant_o]) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Captured address is held for the whole AW phase, independent of the master.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && any_req) aw_addr_p0 <= req_addr;
  end

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = RESP_OKAY;
    awvalid   = 1'b0;
    awaddr    = '0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    bready    = 1'b0;
    case (state)
      ST_AW: begin
        awvalid            = 1'b1;
        awaddr             = aw_addr_p0;
        m_awready[grant_o] = awready;
      end
      ST_W: begin
        wvalid            = m_wvalid[grant_o];
        wlast             = m_wlast[grant_o];
        wdata             = m_wdata[grant_o*DW +: DW];
        wstrb             = m_wstrb[grant_o*SW +: SW];
        m_wready[grant_o] = wready;
      end
      ST_B: begin
        m_bvalid[grant_o] = bvalid;
        m_bresp           = bresp;
        bready            = m_bready[grant_o];
      end
      ST_ERR_W: begin
        if (err_aw_first) m_awready[grant_o] = 1'b1;
        else              m_wready[grant_o]  = 1'b1;
      end
      ST_ERR_B: begin
        m_bvalid[grant_o] = 1'b1;
        m_bresp           = RESP_DECERR;
      end
      default: ;
    endcase
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: a cycle table for the basic and DECERR
// flows, plus hand-written sequences for stalls, round-robin, reset and B hold.
module tb_axi_write_arbiter;

  localparam int NUM_M = 2;
  localparam int DW    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [63:0] m_awaddr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic [0:0]  grant_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  axi_write_arbiter #(.NUM_M(NUM_M), .DW(DW), .NUM_SLV(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  awv;
    logic [31:0] a0, a1;
    logic [1:0]  wv, wl, bry;
    logic        awr, wr, bv;
    logic [1:0]  br;
    logic [45:0] exp;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [1:0] awv, logic [31:0] a0, logic [31:0] a1,
                              logic [1:0] wv, logic [1:0] wl, logic [1:0] bry,
                              logic awr, logic wr, logic bv, logic [1:0] br,
                              logic e_awv, logic [31:0] e_addr, logic [1:0] e_mawr,
                              logic [1:0] e_mwr, logic e_wv, logic e_wl,
                              logic [1:0] e_mbv, logic [1:0] e_br, logic e_bry,
                              logic e_g, logic e_busy);
    vec_t v;
    v.awv = awv; v.a0 = a0; v.a1 = a1; v.wv = wv; v.wl = wl; v.bry = bry;
    v.awr = awr; v.wr = wr; v.bv = bv; v.br = br;
    v.exp = {e_awv, e_addr, e_mawr, e_mwr, e_wv, e_wl, e_mbv, e_br, e_bry, e_g, e_busy};
    return v;
  endfunction

  function automatic logic [31:0] pat(int g, int b);
    return 32'hD000_0000 | 32'(g << 8) | 32'(b);
  endfunction

  function automatic logic [3:0] strb(int b);
    return 4'hF >> (b % 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  // Caller raises the request while the arbiter is idle; returns idle at +2.
  task automatic run_txn(input int g, input logic [31:0] addr, input int beats,
                         input int aw_stall, input bit tog, input int bdelay,
                         input logic [1:0] resp, input bit keep);
    int cyc;
    int beat;
    int hs;
    int wl;
    logic [1:0] gm;
    logic [31:0] d;
    gm  = 2'b01 << g;
    cyc = 0;
    #1;
    while (!awvalid && cyc < 10) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("aw_latency", cyc, 1);
    chk("grant", grant_o, 64'(g));
    for (int s = 0; s < aw_stall; s++) begin
      chk("aw_stall", {awvalid, awaddr, m_awready}, {1'b1, addr, 2'b00});
      @(posedge clk); #2;
    end
    awready = 1'b1;
    #1;
    chk("aw_hs", {awvalid, awaddr, m_awready}, {1'b1, addr, gm});
    @(posedge clk); #1;
    awready = 1'b0;
    if (!keep) m_awvalid[g] = 1'b0;
    beat = 0; hs = 0; wl = 0; cyc = 0;
    while (beat < beats && cyc < 60) begin
      d = pat(g, beat);
      m_wvalid[g] = 1'b1;
      m_wdata[g*32 +: 32] = d;
      m_wstrb[g*4 +: 4] = strb(beat);
      m_wlast[g] = (beat == beats - 1);
      wready = tog ? cyc[0] : 1'b1;
      #1;
      chk("w_fwd", {wvalid, wdata, wstrb, wlast}, {1'b1, d, strb(beat), m_wlast[g]});
      chk("w_ready", m_wready, wready ? gm : 2'b00);
      chk("aw_quiet", m_awready, 2'b00);
      if (wvalid && wready) begin
        hs++;
        if (wlast) wl++;
      end
      if (m_wready[g]) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    m_wvalid[g] = 1'b0;
    m_wlast[g]  = 1'b0;
    wready      = 1'b0;
    chk("w_beats", hs, beats);
    chk("wlast_once", wl, 1);
    bvalid = 1'b1;
    bresp  = resp;
    for (int k = 0; k < bdelay; k++) begin
      m_bready[g] = 1'b0;
      #1;
      chk("b_hold", {m_bvalid, m_bresp, bready, grant_o, busy_o}, {gm, resp, 1'b0, g[0], 1'b1});
      @(posedge clk); #1;
    end
    m_bready[g] = 1'b1;
    #1;
    chk("b_hs", {m_bvalid, m_bresp, bready, grant_o, busy_o}, {gm, resp, 1'b1, g[0], 1'b1});
    @(posedge clk); #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
    m_bready[g] = 1'b0;
    #1;
    chk("b_release", {busy_o, m_bvalid, bready}, {1'b0, 2'b00, 1'b0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a1, a2, a7, z;
    a1 = 32'h1000_0000; a2 = 32'h2000_0000; a7 = 32'h7000_0000; z = 32'h0;
    //               awv  a0  a1  wv    wl    bry   awr wr  bv  br   | awv addr mawr mwr wv wl mbv br bry g busy
    tbl[0]  = mk(2'b00, z,  z,  2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[1]  = mk(2'b01, a1, z,  2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[2]  = mk(2'b01, a1, z,  2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 1, a1, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[3]  = mk(2'b00, a1, z,  2'b01, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[4]  = mk(2'b00, a1, z,  2'b01, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[5]  = mk(2'b00, a1, z,  2'b01, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[6]  = mk(2'b00, a1, z,  2'b01, 2'b01, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b01, 1, 1, 2'b00, 2'b00, 0, 0, 1);
    tbl[7]  = mk(2'b00, a1, z,  2'b00, 2'b00, 2'b01, 1, 1, 1, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1);
    tbl[8]  = mk(2'b00, z,  z,  2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[9]  = mk(2'b10, z,  a7, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[10] = mk(2'b10, z,  a7, 2'b10, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b10, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1);
    tbl[11] = mk(2'b00, z,  a7, 2'b10, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 1);
    tbl[12] = mk(2'b00, z,  a7, 2'b10, 2'b10, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 1);
    tbl[13] = mk(2'b00, z,  a7, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b10, 2'b11, 0, 1, 1);
    tbl[14] = mk(2'b00, z,  a7, 2'b00, 2'b00, 2'b10, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b10, 2'b11, 0, 1, 1);
    tbl[15] = mk(2'b01, a2, a7, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    tbl[16] = mk(2'b01, a2, a7, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 1, a2, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[17] = mk(2'b00, a2, a7, 2'b01, 2'b01, 2'b00, 1, 1, 0, 2'b00, 0, z,  2'b00, 2'b01, 1, 1, 2'b00, 2'b00, 0, 0, 1);
    tbl[18] = mk(2'b00, a2, a7, 2'b00, 2'b00, 2'b01, 1, 1, 1, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1);
    tbl[19] = mk(2'b00, z,  z,  2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, z,  2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wlast = '0; m_wdata = '0;
    m_wstrb = '0; m_bready = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      m_awvalid = tbl[i].awv;
      m_awaddr  = {tbl[i].a1, tbl[i].a0};
      m_wvalid  = tbl[i].wv;
      m_wlast   = tbl[i].wl;
      m_wdata   = {pat(1, i), pat(0, i)};
      m_wstrb   = 8'hFF;
      m_bready  = tbl[i].bry;
      awready   = tbl[i].awr;
      wready    = tbl[i].wr;
      bvalid    = tbl[i].bv;
      bresp     = tbl[i].br;
      #1;
      chk($sformatf("vec%0d", i),
          {awvalid, awaddr, m_awready, m_wready, wvalid, wlast, m_bvalid, m_bresp, bready, grant_o, busy_o},
          tbl[i].exp);
      @(posedge clk); #1;
    end
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // AW stalled five cycles, W ready toggling.
    m_awaddr[31:0] = 32'h0ABC_0000;
    m_awvalid = 2'b01;
    run_txn(0, 32'h0ABC_0000, 4, 5, 1'b1, 0, 2'b00, 1'b0);

    // Simultaneous requests from reset: grant order 0,1,0,1.
    do_reset();
    m_awaddr  = {32'h3000_0010, 32'h1000_0000};
    m_awvalid = 2'b11;
    for (int k = 0; k < 4; k++)
      run_txn(k % 2, (k % 2) ? 32'h3000_0010 : 32'h1000_0000, 2, 0, 1'b0, 0, 2'b00, 1'b1);
    m_awvalid = 2'b00;
    @(posedge clk); #1;

    // Reset mid-W after two of four beats.
    m_awaddr[31:0] = 32'h1000_0000;
    m_awvalid = 2'b01;
    @(posedge clk); #1;
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0; m_awvalid = 2'b00; wready = 1'b1; m_wvalid = 2'b01;
    m_wdata[31:0] = pat(0, 0);
    @(posedge clk); #1;
    m_wdata[31:0] = pat(0, 1);
    @(posedge clk); #1;
    chk("pre_rst_w", {busy_o, wvalid, m_wready}, {1'b1, 1'b1, 2'b01});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_outputs",
        {awvalid, m_awready, m_wready, wvalid, wlast, m_bvalid, m_bresp, bready, grant_o, busy_o}, 64'h0);
    m_wvalid = 2'b00; wready = 1'b0;
    m_awaddr[63:32] = 32'h3000_0000;
    m_awvalid = 2'b10;
    run_txn(1, 32'h3000_0000, 1, 0, 1'b0, 0, 2'b00, 1'b0);

    // B held three cycles with SLVERR, then pointer must favour master 1.
    m_awaddr = {32'h2000_0000, 32'h1000_0000};
    m_awvalid = 2'b01;
    run_txn(0, 32'h1000_0000, 2, 0, 1'b0, 3, 2'b10, 1'b0);
    m_awvalid = 2'b11;
    run_txn(1, 32'h2000_0000, 1, 0, 1'b0, 0, 2'b00, 1'b0);
    run_txn(0, 32'h1000_0000, 1, 0, 1'b0, 0, 2'b00, 1'b0);
    m_awvalid = 2'b00;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
